// File: rtl/key_event_pkg.sv
// key_event_ctrl shared definitions:
// register word addresses and the per-key debounce state.
package key_event_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } deb_state_e;

endpackage

// File: rtl/key_event_ctrl_if.sv
// key_event_ctrl Avalon-MM slave bus bundle.
// master = CPU side, slave = key controller.
interface key_event_ctrl_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/key_debounce_fsm.sv
// One-key debouncer: a level change is accepted after
// DEBOUNCE_CYCLES consecutive cycles of the new level.
module key_debounce_fsm
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The entry cycle already counts as the first stable cycle.
  localparam int LAST_I =
    (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          done;

  assign done  = (cnt_q >= LAST);
  assign level = level_q;

  // Next state; counter clears on each entry and saturates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (key_in) begin
          state_d = PRESS_PENDING;
          cnt_d   = '0;
        end
      end
      PRESS_PENDING: begin
        if (!key_in) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (done) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!key_in) begin
          state_d = RELEASE_PENDING;
          cnt_d   = '0;
        end
      end
      RELEASE_PENDING: begin
        if (key_in) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (done) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
    level_d = (state_d == PRESSED) ||
              (state_d == RELEASE_PENDING);
  end

  // State, counter and registered level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Push-button controller: sync, debounce, sticky press bits.
// KEY_EVENT_IRQ_EN adds the interrupt mask and irq output.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  key_event_ctrl_if.slave     bus,
  input  logic [NUM_KEYS-1:0] in_port
`ifdef KEY_EVENT_IRQ_EN
  ,
  output logic                irq
`endif
);

  // Sync flops hold the inverted pin so reset means released.
  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] edge_q, edge_d;
  logic [31:0]         readdata_q, readdata_d;
  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] edge_clr;
  logic                wr_en;
  logic                unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign bus.readdata = readdata_q;
  assign unused_wdata = ^bus.writedata[31:NUM_KEYS];

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_fsm (
      .clk    (clk),
      .reset_n(reset_n),
      .key_in (sync2_q[k]),
      .level  (level[k]),
      .press  (press[k])
    );
  end

`ifdef KEY_EVENT_IRQ_EN
  logic [NUM_KEYS-1:0] mask_q, mask_d;
  logic                irq_q, irq_d;

  assign irq = irq_q;

  // Mask register write and level interrupt.
  always_comb begin
    mask_d = mask_q;
    if (wr_en && bus.address == ADDR_MASK)
      mask_d = bus.writedata[NUM_KEYS-1:0];
    irq_d = |(edge_q & mask_q);
  end

  // Mask and irq registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end
`endif

  // Sync pipe, sticky edges (set beats clear), read mux.
  always_comb begin
    sync1_d  = ~in_port;
    sync2_d  = sync1_q;
    edge_clr = '0;
    if (wr_en && bus.address == ADDR_EDGE)
      edge_clr = bus.writedata[NUM_KEYS-1:0];
    edge_d = (edge_q & ~edge_clr) | press;

    readdata_d = '0;
    if (bus.chipselect) begin
      unique case (1'b1)
        (bus.address == ADDR_DATA):
          readdata_d[NUM_KEYS-1:0] = level;
        (bus.address == ADDR_RAW):
          readdata_d[NUM_KEYS-1:0] = sync2_q;
        (bus.address == ADDR_MASK): begin
`ifdef KEY_EVENT_IRQ_EN
          readdata_d[NUM_KEYS-1:0] = mask_q;
`else
          readdata_d = '0;
`endif
        end
        (bus.address == ADDR_EDGE):
          readdata_d[NUM_KEYS-1:0] = edge_q;
      endcase
    end
  end

  // Synchronizer, edgecapture and read data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl (NUM_KEYS=2, DEBOUNCE_CYCLES=4):
// vector table, corner sequences, random vs reference model.
module tb_key_event_ctrl;

  localparam int NK  = 2;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NK-1:0] pins;
`ifdef KEY_EVENT_IRQ_EN
  logic          irq;
`endif

  key_event_ctrl_if bus();

  key_event_ctrl #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .in_port(pins)
`ifdef KEY_EVENT_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_model = 1'b0;

  // Reference model: a key's level flips once the synced input
  // has differed from it for DEB consecutive cycles.
  logic [NK-1:0] m_s1, m_s2, m_lvl, m_ec, m_mask;
  int            m_run [NK];
  logic [31:0]   m_rd;
  logic          m_irq;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0;
    m_ec = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
    for (int k = 0; k < NK; k++) m_run[k] = 0;
  endtask

  task automatic model_step();
    logic [NK-1:0] s, prs, clr;
    logic          we;
    s   = m_s2;
    prs = '0;
    m_rd = '0;
    if (bus.chipselect) begin
      case (bus.address)
        2'd0: m_rd[NK-1:0] = m_lvl;
        2'd1: m_rd[NK-1:0] = s;
        2'd2: m_rd[NK-1:0] = m_mask;
        default: m_rd[NK-1:0] = m_ec;
      endcase
    end
    m_irq = |(m_ec & m_mask);
    for (int k = 0; k < NK; k++) begin
      if (s[k] != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin
          m_lvl[k] = s[k];
          m_run[k] = 0;
          if (s[k]) prs[k] = 1'b1;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    we  = bus.chipselect && !bus.write_n;
    clr = (we && bus.address == 2'd3) ? bus.writedata[NK-1:0] : '0;
    m_ec = (m_ec & ~clr) | prs;
`ifdef KEY_EVENT_IRQ_EN
    if (we && bus.address == 2'd2) m_mask = bus.writedata[NK-1:0];
`endif
    m_s2 = m_s1;
    m_s1 = ~pins;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (chk_model) begin
      check("rnd_readdata", bus.readdata, m_rd);
`ifdef KEY_EVENT_IRQ_EN
      check("rnd_irq", {31'd0, irq}, {31'd0, m_irq});
`endif
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.write_n    = 1'b0;
    tick();
    bus.write_n    = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  pins;
    logic        cs;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    vt.push_back('{"idle",        2'b11, 1, 0, 2'd0, 32'd0, 3, 32'd0});
    vt.push_back('{"pre_accept",  2'b10, 1, 0, 2'd0, 32'd0, 6, 32'd0});
    vt.push_back('{"data_k0",     2'b10, 1, 0, 2'd0, 32'd0, 1, 32'd1});
    vt.push_back('{"edge_k0",     2'b10, 1, 0, 2'd3, 32'd0, 1, 32'd1});
    vt.push_back('{"raw_k0",      2'b10, 1, 0, 2'd1, 32'd0, 1, 32'd1});
    vt.push_back('{"mask_zero",   2'b10, 1, 0, 2'd2, 32'd0, 1, 32'd0});
    vt.push_back('{"release",     2'b11, 1, 0, 2'd0, 32'd0, 8, 32'd0});
    vt.push_back('{"clr_rd",      2'b11, 1, 1, 2'd3, 32'd1, 1, 32'd1});
    vt.push_back('{"cleared",     2'b11, 1, 0, 2'd3, 32'd0, 1, 32'd0});
    vt.push_back('{"bounce_a",    2'b10, 1, 0, 2'd0, 32'd0, 3, 32'd0});
    vt.push_back('{"bounce_b",    2'b11, 1, 0, 2'd0, 32'd0, 1, 32'd0});
    vt.push_back('{"bounce_c",    2'b10, 1, 0, 2'd0, 32'd0, 3, 32'd0});
    vt.push_back('{"bounce_data", 2'b11, 1, 0, 2'd0, 32'd0, 6, 32'd0});
    vt.push_back('{"bounce_edge", 2'b11, 1, 0, 2'd3, 32'd0, 1, 32'd0});
    vt.push_back('{"final_press", 2'b10, 1, 0, 2'd3, 32'd0, 7, 32'd1});
    vt.push_back('{"both_press",  2'b00, 1, 0, 2'd3, 32'd0, 7, 32'd3});
    vt.push_back('{"clr01_rd",    2'b00, 1, 1, 2'd3, 32'd1, 1, 32'd3});
    vt.push_back('{"clr01",       2'b00, 1, 0, 2'd3, 32'd0, 1, 32'd2});
    vt.push_back('{"one_shot",    2'b00, 1, 0, 2'd3, 32'd0, 5, 32'd2});
    vt.push_back('{"wr_data_rd",  2'b00, 1, 1, 2'd0, 32'd0, 1, 32'd3});
    vt.push_back('{"data_kept",   2'b00, 1, 0, 2'd0, 32'd0, 1, 32'd3});
    vt.push_back('{"wr_raw_rd",   2'b00, 1, 1, 2'd1, 32'd0, 1, 32'd3});
    vt.push_back('{"raw_kept",    2'b00, 1, 0, 2'd1, 32'd0, 1, 32'd3});
    vt.push_back('{"wr_upper",    2'b00, 1, 1, 2'd3, 32'hFFFF_FFFC, 1, 32'd2});
    vt.push_back('{"upper_kept",  2'b00, 1, 0, 2'd3, 32'd0, 1, 32'd2});
    vt.push_back('{"no_cs",       2'b00, 0, 0, 2'd3, 32'd0, 1, 32'd0});
    vt.push_back('{"cs_back",     2'b00, 1, 0, 2'd3, 32'd0, 1, 32'd2});

    reset_n        = 1'b0;
    pins           = 2'b11;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    model_reset();
    #1;
    check("reset_readdata", bus.readdata, 32'd0);
`ifdef KEY_EVENT_IRQ_EN
    check("reset_irq", {31'd0, irq}, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Table vectors.
    foreach (vt[i]) begin
      pins           = vt[i].pins;
      bus.chipselect = vt[i].cs;
      bus.address    = vt[i].addr;
      bus.writedata  = vt[i].wd;
      bus.write_n    = ~vt[i].wr;
      for (int c = 0; c < vt[i].hold; c++) begin
        tick();
        bus.write_n = 1'b1;
      end
      check(vt[i].name, bus.readdata, vt[i].exp);
    end

    // Press pulse and write-1-clear on the same edge.
    bus.chipselect = 1'b1;
    bus.address    = 2'd3;
    pins = 2'b01;
    run(8);
    pins = 2'b00;
    run(5);
    wr(2'd3, 32'd1);
    tick();
    check("set_wins", bus.readdata, 32'd3);
    wr(2'd3, 32'd3);
    tick();
    check("clear_all", bus.readdata, 32'd0);

    // Mask and interrupt.
    wr(2'd2, 32'd2);
    bus.address = 2'd2;
    tick();
`ifdef KEY_EVENT_IRQ_EN
    check("mask_rd", bus.readdata, 32'd2);
`else
    check("mask_rd", bus.readdata, 32'd0);
`endif
    pins = 2'b11;
    run(8);
    bus.address = 2'd3;
    pins = 2'b10;
    run(8);
    check("k0_edge", bus.readdata, 32'd1);
`ifdef KEY_EVENT_IRQ_EN
    check("irq_masked", {31'd0, irq}, 32'd0);
`endif
    pins = 2'b00;
    run(6);
`ifdef KEY_EVENT_IRQ_EN
    check("irq_pre", {31'd0, irq}, 32'd0);
`endif
    tick();
    check("k1_edge", bus.readdata, 32'd3);
`ifdef KEY_EVENT_IRQ_EN
    check("irq_on", {31'd0, irq}, 32'd1);
`endif
    wr(2'd3, 32'd2);
`ifdef KEY_EVENT_IRQ_EN
    check("irq_hold", {31'd0, irq}, 32'd1);
`endif
    tick();
    check("k1_cleared", bus.readdata, 32'd1);
`ifdef KEY_EVENT_IRQ_EN
    check("irq_off", {31'd0, irq}, 32'd0);
`endif

    // Reset while key1 is mid-debounce.
    pins = 2'b10;
    run(8);
    bus.address = 2'd1;
    pins = 2'b00;
    run(4);
    check("raw_mid", bus.readdata, 32'd3);
    reset_n = 1'b0;
    #1;
    check("rst_readdata", bus.readdata, 32'd0);
`ifdef KEY_EVENT_IRQ_EN
    check("rst_irq", {31'd0, irq}, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    bus.address = 2'd3;
    run(6);
    check("rst_edge_clr", bus.readdata, 32'd0);
    tick();
    check("rst_reaccept", bus.readdata, 32'd3);
    bus.address = 2'd0;
    tick();
    check("rst_data", bus.readdata, 32'd3);

    // Randomized traffic against the model.
    chk_model = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0)
        pins[$urandom_range(0, NK - 1)] ^= 1'b1;
      bus.chipselect = ($urandom_range(0, 7) != 0);
      bus.address    = 2'($urandom_range(0, 3));
      bus.write_n    = ($urandom_range(0, 5) != 0);
      bus.writedata  = $urandom;
      tick();
    end
    chk_model = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
